// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP control/cache slice.
// The entry age field exists only when ARP_AGING_EN is defined.
package arp_pkg;

  localparam int unsigned IP_W  = 32;
  localparam int unsigned MAC_W = 48;
`ifdef ARP_AGING_EN
  localparam int unsigned AGE_W = 32;
`endif

  localparam logic ARP_TYPE_REQ   = 1'b0;
  localparam logic ARP_TYPE_REPLY = 1'b1;

  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

  typedef enum logic [2:0] {
    IDLE,
    TX_REPLY,
    WAIT_REPLY_DONE,
    TX_REQ,
    WAIT_REQ_DONE,
    WAIT_ANSWER
  } arp_state_e;

  typedef struct packed {
    logic             valid;
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
`ifdef ARP_AGING_EN
    logic [AGE_W-1:0] age;
`endif
  } arp_entry_t;

endpackage

// File: rtl/arp_cache.sv
// IP->MAC cache: match/update or round-robin insert, registered parallel lookup.
// Optional per-entry expiry when ARP_AGING_EN is defined.
module arp_cache
  import arp_pkg::*;
#(
  parameter int unsigned CACHE_DEPTH = 4
`ifdef ARP_AGING_EN
  ,
  parameter logic [31:0] AGE_CYCLES  = 32'd1250000000
`endif
) (
  input  logic             gmii_clk,
  input  logic             sys_rst,
  input  logic             wr_en,
  input  logic [IP_W-1:0]  wr_ip,
  input  logic [MAC_W-1:0] wr_mac,
  input  logic             lkp_vld,
  input  logic [IP_W-1:0]  lkp_ip,
  output logic             lkp_ack,
  output logic             lkp_hit,
  output logic [MAC_W-1:0] lkp_mac
);

  localparam int unsigned PTR_W = $clog2(CACHE_DEPTH);

  arp_entry_t       ent_q [CACHE_DEPTH];
  logic [PTR_W-1:0] rr_ptr;

  logic             wr_match_c;
  logic [PTR_W-1:0] wr_idx_c;
  logic [PTR_W-1:0] wr_slot_c;
  arp_entry_t       wr_ent_c;
  logic             lkp_hit_c;
  logic [MAC_W-1:0] lkp_mac_c;

  // Parallel compare of every valid entry against the write and lookup keys
  always_comb begin
    wr_match_c = 1'b0;
    wr_idx_c   = '0;
    lkp_hit_c  = 1'b0;
    lkp_mac_c  = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (ent_q[i].valid && (ent_q[i].ip == wr_ip)) begin
        wr_match_c = 1'b1;
        wr_idx_c   = PTR_W'(i);
      end
      if (ent_q[i].valid && (ent_q[i].ip == lkp_ip)) begin
        lkp_hit_c = 1'b1;
        lkp_mac_c = lkp_mac_c | ent_q[i].mac;
      end
    end
    wr_slot_c      = wr_match_c ? wr_idx_c : rr_ptr;
    wr_ent_c       = '0;
    wr_ent_c.valid = 1'b1;
    wr_ent_c.ip    = wr_ip;
    wr_ent_c.mac   = wr_mac;
  end

  always_ff @(posedge gmii_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < CACHE_DEPTH; i++) ent_q[i] <= '0;
      rr_ptr  <= '0;
      lkp_ack <= 1'b0;
      lkp_hit <= 1'b0;
      lkp_mac <= '0;
    end else begin
      lkp_ack <= lkp_vld;
      lkp_hit <= lkp_vld & lkp_hit_c;
      lkp_mac <= (lkp_vld && lkp_hit_c) ? lkp_mac_c : '0;
`ifdef ARP_AGING_EN
      for (int i = 0; i < CACHE_DEPTH; i++) begin
        if (ent_q[i].valid) begin
          if (ent_q[i].age == (AGE_CYCLES - 32'd1)) ent_q[i].valid <= 1'b0;
          else ent_q[i].age <= ent_q[i].age + 32'd1;
        end
      end
`endif
      // A write overrides same-cycle expiry and restarts the entry's age
      if (wr_en) begin
        ent_q[wr_slot_c] <= wr_ent_c;
        if (!wr_match_c) rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arp_ctrl_cache.sv
// ARP control stage: auto-reply, resolve with timeout/retry, and IP->MAC cache.
// ARP_AGING_EN enables entry expiry after AGE_CYCLES.
module arp_ctrl_cache
  import arp_pkg::*;
#(
  parameter int unsigned CACHE_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 125000,
  parameter int unsigned MAX_RETRY      = 3
`ifdef ARP_AGING_EN
  ,
  parameter logic [31:0] AGE_CYCLES     = 32'd1250000000
`endif
) (
  input  logic             gmii_clk,
  input  logic             sys_rst,
  input  logic             arp_rx_done,
  input  logic             arp_rx_type,
  input  logic [MAC_W-1:0] src_mac,
  input  logic [IP_W-1:0]  src_ip,
  input  logic             tx_done,
  output logic             arp_tx_en,
  output logic             arp_tx_type,
  output logic [MAC_W-1:0] des_mac,
  output logic [IP_W-1:0]  des_ip,
  input  logic             res_start,
  input  logic [IP_W-1:0]  res_ip,
  output logic             res_busy,
  output logic             res_done,
  output logic             res_fail,
  output logic [MAC_W-1:0] res_mac,
  input  logic             lkp_vld,
  input  logic [IP_W-1:0]  lkp_ip,
  output logic             lkp_ack,
  output logic             lkp_hit,
  output logic [MAC_W-1:0] lkp_mac
);

  localparam int unsigned TMO_W = $clog2((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 2);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  arp_state_e       state;
  logic             reply_pend;
  logic [MAC_W-1:0] rep_mac;
  logic [IP_W-1:0]  rep_ip;
  logic [IP_W-1:0]  res_ip_q;
  logic [RTY_W-1:0] rty_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ans_pend;

  logic rx_req_c;
  logic ans_match_c;
  logic tmo_exp_c;

  assign rx_req_c    = arp_rx_done && (arp_rx_type == ARP_TYPE_REQ);
  assign ans_match_c = ans_pend && arp_rx_done && (arp_rx_type == ARP_TYPE_REPLY) &&
                       (src_ip == res_ip_q);
  assign tmo_exp_c   = (tmo_cnt == TMO_LAST);

  always_ff @(posedge gmii_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      reply_pend  <= 1'b0;
      rep_mac     <= '0;
      rep_ip      <= '0;
      res_ip_q    <= '0;
      rty_cnt     <= '0;
      tmo_cnt     <= '0;
      ans_pend    <= 1'b0;
      arp_tx_en   <= 1'b0;
      arp_tx_type <= 1'b0;
      des_mac     <= BCAST_MAC;
      des_ip      <= '0;
      res_busy    <= 1'b0;
      res_done    <= 1'b0;
      res_fail    <= 1'b0;
      res_mac     <= '0;
    end else begin
      arp_tx_en <= 1'b0;
      res_done  <= 1'b0;
      res_fail  <= 1'b0;

      // Answer timer keeps running (saturating) while a reply is being sent
      if (ans_pend && !tmo_exp_c) tmo_cnt <= tmo_cnt + 1'b1;

      if (ans_match_c) begin
        res_done <= 1'b1;
        res_mac  <= src_mac;
        res_busy <= 1'b0;
        ans_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (reply_pend) state <= TX_REPLY;
          else if (res_busy && !ans_pend) state <= TX_REQ;
          else if (ans_pend && !ans_match_c) state <= WAIT_ANSWER;
        end
        TX_REPLY: begin
          arp_tx_en   <= 1'b1;
          arp_tx_type <= ARP_TYPE_REPLY;
          des_mac     <= rep_mac;
          des_ip      <= rep_ip;
          reply_pend  <= 1'b0;
          state       <= WAIT_REPLY_DONE;
        end
        WAIT_REPLY_DONE: begin
          if (tx_done) state <= IDLE;
        end
        TX_REQ: begin
          arp_tx_en   <= 1'b1;
          arp_tx_type <= ARP_TYPE_REQ;
          des_mac     <= BCAST_MAC;
          des_ip      <= res_ip_q;
          rty_cnt     <= rty_cnt + 1'b1;
          state       <= WAIT_REQ_DONE;
        end
        WAIT_REQ_DONE: begin
          if (tx_done) begin
            tmo_cnt  <= '0;
            ans_pend <= 1'b1;
            state    <= WAIT_ANSWER;
          end
        end
        WAIT_ANSWER: begin
          if (!ans_pend || ans_match_c) begin
            state <= IDLE;
          end else if (reply_pend) begin
            state <= TX_REPLY;
          end else if (tmo_exp_c) begin
            ans_pend <= 1'b0;
            if (rty_cnt < RTY_MAX) begin
              state <= TX_REQ;
            end else begin
              res_fail <= 1'b1;
              res_busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Event capture comes last so a fresh event beats a same-cycle clear
      if (rx_req_c) begin
        reply_pend <= 1'b1;
        rep_mac    <= src_mac;
        rep_ip     <= src_ip;
      end
      if (res_start && !res_busy) begin
        res_busy <= 1'b1;
        res_ip_q <= res_ip;
        rty_cnt  <= '0;
      end
    end
  end

  arp_cache #(
    .CACHE_DEPTH (CACHE_DEPTH)
`ifdef ARP_AGING_EN
    ,
    .AGE_CYCLES  (AGE_CYCLES)
`endif
  ) u_cache (
    .gmii_clk (gmii_clk),
    .sys_rst  (sys_rst),
    .wr_en    (arp_rx_done),
    .wr_ip    (src_ip),
    .wr_mac   (src_mac),
    .lkp_vld  (lkp_vld),
    .lkp_ip   (lkp_ip),
    .lkp_ack  (lkp_ack),
    .lkp_hit  (lkp_hit),
    .lkp_mac  (lkp_mac)
  );

endmodule

// File: doc/arp_ctrl_cache.md
Name: arp_ctrl_cache

Overview:
- Control stage directly upstream of the ARP transceiver.
- Consumes its receive outputs (arp_rx_done, arp_rx_type, src_mac, src_ip) and drives its transmit inputs (arp_tx_en, arp_tx_type, des_mac, des_ip), handshaking on tx_done.
- Auto-replies to incoming ARP requests.
- Resolves user-requested IPs with timeout and retry.
- Keeps a small IP->MAC cache that the UDP/IP layer looks up.

Parameters:
- CACHE_DEPTH, 4, number of cache entries (power of two, 2..16).
- TIMEOUT_CYCLES, 125000, clock cycles to wait for an ARP reply per attempt.
- MAX_RETRY, 3, request transmissions per resolve before failure.
- AGE_CYCLES, 32'd1250000000, entry lifetime in cycles; used only with ARP_AGING_EN.

Ports:
- gmii_clk  in  1  GMII clock, 125 MHz; shared by the ARP rx and tx paths.
- sys_rst  in  1  reset, synchronous, active-high.
- arp_rx_done  in  1  one-cycle pulse: ARP frame received.
- arp_rx_type  in  1  0 = request, 1 = reply; valid with arp_rx_done.
- src_mac  in  48  sender MAC of received frame.
- src_ip  in  32  sender IP of received frame.
- tx_done  in  1  one-cycle pulse: ARP frame transmission finished.
- arp_tx_en  out  1  one-cycle transmit start pulse.
- arp_tx_type  out  1  0 = request, 1 = reply; held from pulse to tx_done.
- des_mac  out  48  target MAC for transmit; held from pulse to tx_done.
- des_ip  out  32  target IP for transmit; held from pulse to tx_done.
- res_start  in  1  pulse: resolve res_ip; ignored while res_busy = 1.
- res_ip  in  32  IP to resolve; sampled on res_start.
- res_busy  out  1  resolve in progress.
- res_done  out  1  pulse: resolve succeeded; res_mac valid in the same cycle.
- res_fail  out  1  pulse: resolve failed after MAX_RETRY attempts.
- res_mac  out  48  resolved MAC; held until next res_done.
- lkp_vld  in  1  cache lookup strobe.
- lkp_ip  in  32  lookup key.
- lkp_ack  out  1  pulse one cycle after lkp_vld.
- lkp_hit  out  1  valid with lkp_ack.
- lkp_mac  out  48  valid with lkp_ack; 0 when lkp_hit = 0.

Behaviour:
- Reset:
  - All outputs 0, except des_mac = 48'hFF_FF_FF_FF_FF_FF.
  - Cache entries invalid.
  - FSM in IDLE.
  - Reply-pending and resolve-pending flags cleared.
  - Reset mid-transmit abandons the operation; a late tx_done is ignored in IDLE.
- Event capture, every cycle independent of FSM state:
  - arp_rx_done with type 0 sets reply_pend and latches src_mac/src_ip as the reply target; a newer request overwrites an older pending one.
  - res_start with res_busy = 0 sets res_busy, latches res_ip and clears the retry counter.
- Cache write, on arp_rx_done of either type:
  - If src_ip matches a valid entry, update that entry's MAC.
  - Otherwise write the slot at the round-robin pointer (width clog2(CACHE_DEPTH), wraps) and increment the pointer.
  - The write completes in the cycle after arp_rx_done.
- FSM states: IDLE, TX_REPLY, WAIT_REPLY_DONE, TX_REQ, WAIT_REQ_DONE, WAIT_ANSWER.
  - IDLE: reply_pend has priority → TX_REPLY. Else res_busy with no answer outstanding → TX_REQ. Else, in WAIT_ANSWER context, return there.
  - TX_REPLY: arp_tx_en = 1 for one cycle, type = 1, des_mac/des_ip = latched target; clear reply_pend → WAIT_REPLY_DONE.
  - WAIT_REPLY_DONE: on tx_done → IDLE, resuming a pending WAIT_ANSWER with its timer not reset.
  - TX_REQ: arp_tx_en pulse, type = 0, des_mac = all-ones, des_ip = latched res_ip; increment the retry counter → WAIT_REQ_DONE.
  - WAIT_REQ_DONE: on tx_done → WAIT_ANSWER and clear the timeout counter.
  - WAIT_ANSWER: counter increments each cycle.
    - Reply with src_ip == latched IP: res_mac = src_mac and res_done pulses one cycle after arp_rx_done; res_busy clears → IDLE.
    - Counter reaching TIMEOUT_CYCLES-1 with retry < MAX_RETRY → TX_REQ.
    - Counter reaching TIMEOUT_CYCLES-1 with retry == MAX_RETRY → res_fail pulse, res_busy clears → IDLE.
    - reply_pend → TX_REPLY, with the timer still running.
- Simultaneous events:
  - Matching reply and timeout in the same cycle: the reply wins.
  - Request rx and res_start in the same cycle: both are captured; the reply is sent first.
- Resolve when the target is already cached: res_start on a cached IP still transmits a request; it does not short-circuit.
- Lookup:
  - Registered; all entries compared in parallel.
  - lkp_ack/lkp_hit/lkp_mac appear one cycle after lkp_vld.
  - A lookup in the same cycle as a cache write sees the pre-write contents.

Optional Feature:
- ARP_AGING_EN defined:
  - Each entry has a 32-bit age counter, cleared on write.
  - An entry becomes invalid when its counter reaches AGE_CYCLES-1.
  - An invalidated entry's slot stays eligible for round-robin replacement.
- ARP_AGING_EN undefined: entries never expire; no age counters are synthesized.

Decomposition:
- Package arp_pkg:
  - FSM state enum.
  - ARP_TYPE_REQ = 0, ARP_TYPE_REPLY = 1.
  - BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF.
  - Cache entry struct {valid, ip[31:0], mac[47:0], age}.
- Sub-module arp_cache: storage, match/update, round-robin pointer, lookup port and aging.
- The FSM and timers stay in arp_ctrl_cache.

Test Plan:
- Auto-reply:
  - Stimulus: request rx, src_ip C0A80166, src_mac 001122334455.
  - Response: one arp_tx_en pulse, type 1, des_ip C0A80166, des_mac 001122334455.
  - After tx_done, lkp C0A80166 gives hit with mac 001122334455.
- Resolve success:
  - Stimulus: res_start with ip C0A80166; tx_done; reply from C0A80166 mac A0B0C0D0E0F0 after 50 cycles.
  - Response: res_done pulse with res_mac A0B0C0D0E0F0; res_busy drops.
- Resolve failure:
  - Stimulus: no reply, TIMEOUT_CYCLES = 100.
  - Response: exactly 3 request pulses, spaced 100 cycles after each tx_done; then one res_fail pulse.
- Interleaving:
  - Stimulus: a request from C0A80103 arrives during WAIT_ANSWER.
  - Response: the reply is transmitted first; the original resolve still times out/retries on its original schedule.
- Cache replacement:
  - Stimulus: 5 distinct replies with CACHE_DEPTH = 4.
  - Response: the first IP misses, the last 4 hit; re-sending a reply for an existing IP updates its MAC without consuming a slot.
- Reset and aging:
  - Stimulus: sys_rst asserted mid-WAIT_REQ_DONE.
  - Response: all outputs 0 and cache empty.
  - With ARP_AGING_EN and AGE_CYCLES = 200: an entry hits at cycle 199 after write and misses at cycle 201.
